// File: rtl/decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : decoder_pkg
// Description : Shared definitions for the decoder_scan block: mode encodings
//               and default widths for the select index and scan prescaler.
// Revision    : 1.0 - initial release
// ============================================================================
package decoder_pkg;

    // Default select/index width (decoded output is 2**SEL_W bits wide)
    localparam int SEL_W_DEF = 3;
    // Default scan prescaler width
    localparam int DIV_W_DEF = 16;

    // Operating mode encodings carried on i_mode
    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage : decoder_pkg
`default_nettype wire

// File: rtl/decoder_tick.sv
`default_nettype none
// ============================================================================
// Module      : decoder_tick
// Description : Scan-step prescaler. Counts 0..i_div while running and
//               raises o_tick on the cycle the count reaches (or exceeds)
//               i_div, then restarts from 0. A lowered i_div therefore takes
//               effect at once. i_clr zeroes the count and suppresses the tick.
// Ports       : i_clk   - clock, rising-edge active
//               i_rst_n - asynchronous active-low reset
//               i_run   - count enable; count holds when low
//               i_clr   - synchronous clear, wins over i_run
//               i_div   - step period minus one, in clocks
//               o_tick  - combinational step strobe for the current cycle
// Revision    : 1.0 - initial release
// ============================================================================
module decoder_tick #(
    parameter int DIV_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_run,
    input  logic             i_clr,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_tick
);

    logic [DIV_W-1:0] r_cnt;

    // >= rather than == so that shrinking i_div below the current count
    // ticks immediately instead of running all the way round.
    assign o_tick = i_run & ~i_clr & (r_cnt >= i_div);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_run) begin
            if (o_tick) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + DIV_W'(1);
            end
        end
    end

endmodule : decoder_tick
`default_nettype wire

// File: rtl/decoder_scan.sv
`default_nettype none
// ============================================================================
// Module      : decoder_scan
// Description : Registered N-to-2**N decoder with direct-select and automatic
//               scan modes. The decoded one-hot vector is registered; only the
//               output polarity (i_opt) is applied combinationally.
// Ports       : i_clk   - clock, rising-edge active
//               i_rst_n - asynchronous active-low reset
//               i_en    - enable; low blanks o_y and freezes scan state
//               i_mode  - 0 direct decode of i_sel, 1 automatic scan
//               i_sel   - direct-mode select
//               i_last  - highest index visited while scanning
//               i_div   - scan step period minus one, in clocks
//               i_opt   - 0 active-low one-cold, 1 active-high one-hot
//               o_y     - decoded output
//               o_idx   - index currently driven on o_y
//               o_wrap  - one-cycle pulse when the scan returns to index 0
// Revision    : 1.0 - initial release
// ============================================================================
module decoder_scan
    import decoder_pkg::*;
#(
    parameter int SEL_W = SEL_W_DEF,
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_en,
    input  logic                 i_mode,
    input  logic [SEL_W-1:0]     i_sel,
    input  logic [SEL_W-1:0]     i_last,
    input  logic [DIV_W-1:0]     i_div,
    input  logic                 i_opt,
    output logic [2**SEL_W-1:0]  o_y,
    output logic [SEL_W-1:0]     o_idx,
    output logic                 o_wrap
);

    localparam int OUT_W = 2**SEL_W;

    logic [OUT_W-1:0] r_hot;
    logic [SEL_W-1:0] r_idx;
    logic             r_wrap;
    logic             r_mode_prev;

    logic             w_scan;
    logic             w_mode_start;
    logic             w_run;
    logic             w_tick;
    logic             w_at_last;
    logic [SEL_W-1:0] w_next_idx;

    function automatic logic [OUT_W-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [OUT_W-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // The previous mode is only sampled while enabled, so a switch into scan
    // made while disabled still restarts the scan once enable returns.
    assign w_scan       = (i_mode == MODE_SCAN);
    assign w_mode_start = i_en & w_scan & (r_mode_prev == MODE_DIRECT);
    assign w_run        = i_en & w_scan & ~w_mode_start;

    assign w_at_last  = (r_idx >= i_last);
    assign w_next_idx = w_at_last ? '0 : r_idx + SEL_W'(1);

    decoder_tick #(
        .DIV_W (DIV_W)
    ) u_tick (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_run   (w_run),
        .i_clr   (w_mode_start),
        .i_div   (i_div),
        .o_tick  (w_tick)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hot       <= '0;
            r_idx       <= '0;
            r_wrap      <= 1'b0;
            r_mode_prev <= MODE_DIRECT;
        end else if (!i_en) begin
            // Blank the output; index and mode history hold.
            r_hot  <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_mode_prev <= i_mode;
            if (!w_scan) begin
                r_hot  <= onehot(i_sel);
                r_idx  <= i_sel;
                r_wrap <= 1'b0;
            end else if (w_mode_start) begin
                // Entering scan restarts at index 0; no step on this edge.
                r_hot  <= onehot('0);
                r_idx  <= '0;
                r_wrap <= 1'b0;
            end else if (w_tick) begin
                r_hot  <= onehot(w_next_idx);
                r_idx  <= w_next_idx;
                r_wrap <= w_at_last;
            end else begin
                // Regenerate from the held index (needed after re-enable).
                r_hot  <= onehot(r_idx);
                r_wrap <= 1'b0;
            end
        end
    end

    assign o_y    = i_opt ? r_hot : ~r_hot;
    assign o_idx  = r_idx;
    assign o_wrap = r_wrap;

endmodule : decoder_scan
`default_nettype wire

// File: doc/decoder_scan.md
DECODER_SCAN -- requirements
Module: decoder_scan

Interface
REQ-001 SHALL have parameter SEL_W, default 3, meaning select/index width (1..6).
REQ-002 SHALL have parameter DIV_W, default 16, meaning scan prescaler width.
REQ-003 SHALL have derived localparam OUT_W = 2**SEL_W, meaning the decoded output width; it is not overridable.
REQ-004 SHALL have port i_clk  input  1  the single clock; all state is updated on its rising edge.
REQ-005 SHALL have port i_rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port i_en  input  1  enable; 0 forces outputs inactive and freezes scan state.
REQ-007 SHALL have port i_mode  input  1  0 = direct decode of i_sel, 1 = automatic scan.
REQ-008 SHALL have port i_sel  input  SEL_W  direct-mode select.
REQ-009 SHALL have port i_last  input  SEL_W  highest index visited in scan mode.
REQ-010 SHALL have port i_div  input  DIV_W  scan step period minus one, in clocks.
REQ-011 SHALL have port i_opt  input  1  polarity: 0 = active-low one-cold, 1 = active-high one-hot.
REQ-012 SHALL have port o_y  output  OUT_W  decoded output.
REQ-013 SHALL have port o_idx  output  SEL_W  index currently driven on o_y.
REQ-014 SHALL have port o_wrap  output  1  single-cycle pulse when the scan wraps from i_last to 0.

Function
REQ-015 SHALL hold an internal registered one-hot vector r_hot (OUT_W bits); o_y SHALL equal r_hot when i_opt=1 and ~r_hot when i_opt=0, with the polarity path purely combinational (0-cycle).
REQ-016 In direct mode with i_en=1, r_hot SHALL become 1<<i_sel and o_idx SHALL become i_sel on the next edge (1-cycle latency).
REQ-017 With i_en=0, r_hot SHALL become all-zero on the next edge (o_y all inactive); o_idx, the prescaler and o_wrap state SHALL hold, and o_wrap SHALL be 0.
REQ-018 In scan mode with i_en=1, the prescaler SHALL count 0..i_div and generate a tick on the cycle it equals i_div, then return to 0.
REQ-019 On a tick, the scan index SHALL advance by 1, or go to 0 if the index is >= i_last; r_hot and o_idx SHALL follow the new index on the same edge.
REQ-020 o_wrap SHALL be 1 for exactly the one cycle after an edge on which the index went from >= i_last to 0, and 0 otherwise.
REQ-021 i_div=0 SHALL advance the index on every clock; i_last=0 SHALL hold index 0 and pulse o_wrap on every tick.
REQ-022 A change of i_mode from 0 to 1 SHALL clear the prescaler and the scan index to 0 on that edge, and no tick or o_wrap SHALL occur on that edge (the mode change wins over a simultaneous tick).
REQ-023 A change of i_mode from 1 to 0 SHALL resume direct decode on the next edge with o_wrap=0.
REQ-024 Lowering i_last below the current index mid-scan SHALL send the index to 0 on the next tick, with o_wrap pulsing.
REQ-025 Changes to i_div mid-count SHALL take effect immediately: if the prescaler is >= the new i_div, it SHALL tick on the current cycle.

Reset
REQ-026 While i_rst_n=0 (asynchronous assert, synchronous-edge release), the following SHALL hold: r_hot=0 (o_y all inactive per the current i_opt), o_idx=0, prescaler=0, o_wrap=0.
REQ-027 The first update after reset release SHALL occur on the first rising edge with i_rst_n=1; reset applied mid-scan SHALL abandon the scan, and the block SHALL restart from index 0.

Structure
REQ-028 The mode encodings (MODE_DIRECT=0, MODE_SCAN=1) and the default SEL_W/DIV_W values SHALL live in shared package decoder_pkg.
REQ-029 The prescaler SHALL be the sub-module decoder_tick (ports i_clk, i_rst_n, i_run, i_clr, i_div, o_tick).
REQ-030 The block SHALL have no latches and no combinational path from i_sel/i_mode to o_y; only i_opt SHALL be combinational to o_y.

Verification
REQ-031 Reset then direct, i_opt=0, i_sel=3'd5 -> o_y=8'b11011111 and o_idx=5 one cycle later; toggling i_opt=1 SHALL make o_y=8'b00100000 in the same cycle.
REQ-032 Scan, i_div=2, i_last=7 -> the index SHALL step every 3 clocks through 0..7, and o_wrap SHALL pulse once per 24 clocks, coincident with o_idx returning to 0.
REQ-033 Scan, i_div=0, i_last=2, then i_last changed to 1 while o_idx=2 -> the next clock SHALL give o_idx=0 with o_wrap=1, followed by the sequence 1,0,1,0.
REQ-034 Scan with i_en dropped for 5 cycles at o_idx=4 -> o_y SHALL be all inactive and o_idx SHALL stay 4; after re-enable, stepping SHALL resume from the held prescaler value.
REQ-035 i_rst_n asserted asynchronously mid-scan, between clock edges -> o_y SHALL go inactive immediately, and o_idx=0 and o_wrap=0 SHALL hold before the next edge.
REQ-036 Parameter sweep SEL_W=1,2,4 in direct mode with all i_sel values -> o_y SHALL be exactly one active bit at position i_sel.
